sram_arbiter: RTL and testbench

Two-master, one-slave arbiter for the SRAM-like memory port of the CPU core. It sits between the instruction-fetch port and the EX/MEM data port (data_sram_*) on one side, and the single shared SRAM-like bus toward the AXI bridge on the other. It grants one address phase at a time and keeps the grant ID of every accepted request in order, so each data_ok/rdata response is returned to the master that issued it. Supports multiple outstanding transactions, with in-order responses.

---
 rtl/sram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master / one-slave arbiter for the SRAM-like memory port.
//
// Grants one address phase at a time to either the instruction-fetch master
// (inst_*) or the data master (data_*), records the grantee of every accepted
// request in an order FIFO, and routes each in-order response (data_ok/rdata)
// back to the master that issued it.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wstrb/wdata     instruction master request
//   inst_addr_ok/data_ok/rdata            instruction master response
//   data_req/wr/size/addr/wstrb/wdata     data master request
//   data_addr_ok/data_ok/rdata            data master response
//   req/wr/size/addr/wstrb/wdata          shared-bus request
//   addr_ok/data_ok/rdata                 shared-bus response
//
// Parameter OUTSTANDING: order FIFO depth (power of 2, 2..16).
// Macro SRAM_ARB_RR_EN: when defined, round-robin arbitration on a tie;
// otherwise fixed priority with data over inst.

module sram_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared bus
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StGntInst, StGntData} state_e;

    state_e                 state_q, state_d;
    logic                   gnt_inst, gnt_data;
    logic                   full, accept, pop, head_id;
    logic                   pick_data_on_tie;
    logic [PtrW-1:0]        wptr_q, rptr_q;
    logic [CntW-1:0]        count_q;
    logic [OUTSTANDING-1:0] id_q;   // 0 = inst, 1 = data

`ifdef SRAM_ARB_RR_EN
    logic last_q;   // last accepted winner: 0 = inst, 1 = data

    assign pick_data_on_tie = ~last_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= gnt_data;
        end
    end
`else
    assign pick_data_on_tie = 1'b1;
`endif

    assign full    = (count_q == CntW'(OUTSTANDING));
    assign accept  = req & addr_ok;
    // A response with nothing outstanding is ignored.
    assign pop     = data_ok & (count_q != '0);
    assign head_id = id_q[rptr_q];

    // Grant: combinational out of idle, held until the address phase completes.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!full) begin
                    if (data_req && (!inst_req || pick_data_on_tie)) begin
                        gnt_data = 1'b1;
                    end else if (inst_req) begin
                        gnt_inst = 1'b1;
                    end
                end
            end
            StGntInst: gnt_inst = 1'b1;
            StGntData: gnt_data = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StIdle;
        end else if (gnt_data) begin
            state_d = StGntData;
        end else if (gnt_inst) begin
            state_d = StGntInst;
        end
    end

    // Request mux; bus req is masked while the order FIFO is full.
    always_comb begin
        req   = 1'b0;
        wr    = 1'b0;
        size  = 2'b0;
        addr  = 32'b0;
        wstrb = 4'b0;
        wdata = 32'b0;
        if (gnt_data) begin
            req   = data_req & ~full;
            wr    = data_wr;
            size  = data_size;
            addr  = data_addr;
            wstrb = data_wstrb;
            wdata = data_wdata;
        end else if (gnt_inst) begin
            req   = inst_req & ~full;
            wr    = inst_wr;
            size  = inst_size;
            addr  = inst_addr;
            wstrb = inst_wstrb;
            wdata = inst_wdata;
        end
    end

    // Response routing.
    always_comb begin
        inst_addr_ok = gnt_inst & accept;
        data_addr_ok = gnt_data & accept;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'b0;
        data_rdata   = 32'b0;
        if (pop) begin
            if (head_id) begin
                data_data_ok = 1'b1;
                data_rdata   = rdata;
            end else begin
                inst_data_ok = 1'b1;
                inst_rdata   = rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Order FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                id_q[wptr_q] <= gnt_data;
                wptr_q       <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h0000_1000;
    localparam logic [31:0] XR = 32'hDEAD_BEEF;   // bus rdata when no data_ok

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        req, wr, addr_ok, data_ok;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    vec_t post[$];

    function automatic vec_t mk(input logic ir, dr, aok, dok, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_iaok, e_daok, e_idok, e_ddok,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
        v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        inst_req = v.ir;
        data_req = v.dr;
        addr_ok  = v.aok;
        data_ok  = v.dok;
        rdata    = v.rd;
        #2;
        check("req",          idx, {31'b0, req},          {31'b0, v.e_req});
        check("addr",         idx, addr,                  v.e_addr);
        check("wr",           idx, {31'b0, wr},           {31'b0, v.e_addr == DA});
        check("inst_addr_ok", idx, {31'b0, inst_addr_ok}, {31'b0, v.e_iaok});
        check("data_addr_ok", idx, {31'b0, data_addr_ok}, {31'b0, v.e_daok});
        check("inst_data_ok", idx, {31'b0, inst_data_ok}, {31'b0, v.e_idok});
        check("data_data_ok", idx, {31'b0, data_data_ok}, {31'b0, v.e_ddok});
        check("inst_rdata",   idx, inst_rdata,            v.e_idok ? v.e_rdata : 32'b0);
        check("data_rdata",   idx, data_rdata,            v.e_ddok ? v.e_rdata : 32'b0);
    endtask

    initial begin
        logic rr;
`ifdef SRAM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // Single inst read, response two cycles later.
        vecs.push_back(mk(1, 0, 1, 0, XR,           1, IA, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, XR,           0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h02800C06, 0, 0,  0, 0, 1, 0, 32'h02800C06));
        // Simultaneous requests, addr_ok low for 3 cycles: grant held on data.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, XR, 1, DA, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, XR,    1, DA, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, XR,    1, IA, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 32'h55));
        vecs.push_back(mk(0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 1, 0, 32'h66));
        // Interleaved inst, data, inst; responses A, B, C (A overlaps the third push).
        vecs.push_back(mk(1, 0, 1, 0, XR,    1, IA, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, XR,    1, DA, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'hA, 1, IA, 1, 0, 1, 0, 32'hA));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB, 0, 0,  0, 0, 0, 1, 32'hB));
        vecs.push_back(mk(0, 0, 0, 1, 32'hC, 0, 0,  0, 0, 1, 0, 32'hC));
        // Fill to 4 outstanding, fifth blocked, one pop, then accepted again.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 1, 0, XR, 1, IA, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, XR,     0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h11, 0, 0,  0, 0, 1, 0, 32'h11));
        vecs.push_back(mk(1, 0, 1, 0, XR,     1, IA, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 1, 32'h30 + i, 0, 0, 0, 0, 1, 0, 32'h30 + i));
        // Both request continuously with immediate addr_ok.
        for (int i = 0; i < 4; i++) begin
            logic d;
            d = rr ? (i % 2 == 0) : 1'b1;
            vecs.push_back(mk(1, 1, 1, 0, XR, 1, d ? DA : IA, !d, d, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 1, 32'h21, 0, 0, 0, 0, 0, 1, 32'h21));
        vecs.push_back(mk(0, 0, 0, 1, 32'h22, 0, 0, 0, 0, rr, !rr, 32'h22));
        // Two transactions left outstanding here; reset follows.

        // After reset: stray data_ok ignored, then the FIFO holds exactly 4 again.
        post.push_back(mk(0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) post.push_back(mk(1, 0, 1, 0, XR, 1, IA, 1, 0, 0, 0, 0));
        post.push_back(mk(1, 0, 1, 0, XR, 0, 0, 0, 0, 0, 0, 0));

        inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IA; inst_wstrb = 4'h0;
        inst_wdata = 32'h1111_1111;
        data_wr = 1'b1; data_size = 2'd2; data_addr = DA; data_wstrb = 4'hF;
        data_wdata = 32'h2222_2222;
        inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = XR;
        resetn = 1'b0;

        @(negedge clk);
        #2;
        check("reset_req",     -1, {31'b0, req}, 32'b0);
        check("reset_addr",    -1, addr, 32'b0);
        check("reset_addr_ok", -1, {30'b0, inst_addr_ok, data_addr_ok}, 32'b0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Asynchronous reset mid-cycle with two outstanding; data_ok during reset.
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h99;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_inst_data_ok", -2, {31'b0, inst_data_ok}, 32'b0);
        check("rst_data_data_ok", -2, {31'b0, data_data_ok}, 32'b0);
        check("rst_rdata",        -2, inst_rdata | data_rdata, 32'b0);
        check("rst_req",          -2, {31'b0, req}, 32'b0);
        @(negedge clk);
        data_ok = 1'b0;
        resetn  = 1'b1;

        foreach (post[i]) run_vec(post[i], 100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
